uart: RTL and testbench

Full-duplex 8N1 UART with 16x-oversampled receiver, transmitter and a FIFO on each direction. Sits between a serial pin pair and a synchronous host that pushes bytes for transmission and pops received bytes. The shipped configuration is 19200 baud from a 50 MHz clock.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_fifo.sv | 92 +++++++++
 rtl/uart.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart block: FSM encodings and default frame/baud constants.
`timescale 1ns/1ps
package uart_pkg;

    // Receiver FSM encoding
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Transmitter FSM encoding
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Shipped configuration: 8N1 at 19200 baud from 50 MHz, 4-deep FIFOs
    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;
    localparam int DEF_DVSR    = 163;
    localparam int DEF_FIFO_W  = 2;

    // Oversampling: ticks per bit and the tick index at mid-start-bit
    localparam int OS_LAST   = 15;
    localparam int START_MID = 7;

endpackage

// File: rtl/uart_fifo.sv
// Circular-buffer FIFO with registered full/empty flags and first-word fall-through read port.
`timescale 1ns/1ps
module uart_fifo #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic         empty,
    output logic         full,
    output logic [B-1:0] r_data
);

    logic [B-1:0] mem [2**W];
    logic [W-1:0] w_ptr, w_ptr_n, w_ptr_inc;
    logic [W-1:0] r_ptr, r_ptr_n, r_ptr_inc;
    logic         full_reg, full_n;
    logic         empty_reg, empty_n;
    logic         do_wr;

    assign w_ptr_inc = w_ptr + 1'b1;
    assign r_ptr_inc = r_ptr + 1'b1;

    // Storage array; cleared on reset, written at the tail when a push is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**W; i++) mem[i] <= '0;
        end else if (do_wr) begin
            mem[w_ptr] <= w_data;
        end
    end

    // Pointer and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            w_ptr     <= w_ptr_n;
            r_ptr     <= r_ptr_n;
            full_reg  <= full_n;
            empty_reg <= empty_n;
        end
    end

    // Next pointers/flags; a simultaneous push+pop on an empty FIFO degrades to a push
    always_comb begin
        w_ptr_n = w_ptr;
        r_ptr_n = r_ptr;
        full_n  = full_reg;
        empty_n = empty_reg;
        do_wr   = 1'b0;
        case ({wr, rd})
            2'b01: begin
                if (!empty_reg) begin
                    r_ptr_n = r_ptr_inc;
                    full_n  = 1'b0;
                    empty_n = (r_ptr_inc == w_ptr);
                end
            end
            2'b10: begin
                if (!full_reg) begin
                    do_wr   = 1'b1;
                    w_ptr_n = w_ptr_inc;
                    empty_n = 1'b0;
                    full_n  = (w_ptr_inc == r_ptr);
                end
            end
            2'b11: begin
                do_wr   = 1'b1;
                w_ptr_n = w_ptr_inc;
                if (empty_reg) begin
                    empty_n = 1'b0;
                    full_n  = (w_ptr_inc == r_ptr);
                end else begin
                    r_ptr_n = r_ptr_inc;
                end
            end
            default: ;
        endcase
    end

    assign empty  = empty_reg;
    assign full   = full_reg;
    assign r_data = mem[r_ptr];

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART: baud tick generator, 16x-oversampled receiver, transmitter, FIFO per direction.
`timescale 1ns/1ps
module uart
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int DVSR    = DEF_DVSR,
    parameter int FIFO_W  = DEF_FIFO_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_uart,
    input  logic       wr_uart,
    input  logic       rx,
    input  logic [7:0] w_data,
    output logic       tx_full,
    output logic       rx_empty,
    output logic       tx,
    output logic [7:0] r_data
);

    localparam int CW = $clog2(DVSR);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = $clog2(DBIT);

    logic [CW-1:0] baud_cnt;
    logic          tick;

    logic          rx_p0, rx_p1;

    rx_state_t     rx_state, rx_state_n;
    logic [SW-1:0] rx_s, rx_s_n;
    logic [NW-1:0] rx_n, rx_n_n;
    logic [7:0]    rx_b, rx_b_n;
    logic          rx_done;
    logic          rx_fifo_full, rx_fifo_wr;

    tx_state_t     tx_state, tx_state_n;
    logic [SW-1:0] tx_s, tx_s_n;
    logic [NW-1:0] tx_n, tx_n_n;
    logic [7:0]    tx_b, tx_b_n;
    logic          tx_reg, tx_next;
    logic          tx_pop;
    logic          tx_fifo_empty;
    logic [7:0]    tx_fifo_dout;

    // Free-running oversample tick: one clk pulse every DVSR clocks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) baud_cnt <= '0;
        else if (baud_cnt == CW'(DVSR - 1)) baud_cnt <= '0;
        else baud_cnt <= baud_cnt + 1'b1;
    end

    assign tick = (baud_cnt == CW'(DVSR - 1));

    // Two-flop synchronizer on the serial input; preset to the idle-high line level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_s     <= rx_s_n;
            rx_n     <= rx_n_n;
            rx_b     <= rx_b_n;
        end
    end

    // Receiver next state: verify start at mid-bit, sample data at mid-bit, wait out the stop bit
    always_comb begin
        rx_state_n = rx_state;
        rx_s_n     = rx_s;
        rx_n_n     = rx_n;
        rx_b_n     = rx_b;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_p1) begin
                    rx_state_n = RX_START;
                    rx_s_n     = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_s == SW'(START_MID)) begin
                        if (!rx_p1) begin
                            rx_state_n = RX_DATA;
                            rx_s_n     = '0;
                            rx_n_n     = '0;
                        end else begin
                            rx_state_n = RX_IDLE;
                        end
                    end else begin
                        rx_s_n = rx_s + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_s == SW'(OS_LAST)) begin
                        rx_s_n = '0;
                        rx_b_n = {rx_p1, rx_b[7:1]};
                        if (rx_n == NW'(DBIT - 1)) rx_state_n = RX_STOP;
                        else rx_n_n = rx_n + 1'b1;
                    end else begin
                        rx_s_n = rx_s + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_s == SW'(SB_TICK - 1)) rx_state_n = RX_IDLE;
                    else rx_s_n = rx_s + 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // Receiver output: one-clk byte-complete strobe at the end of the stop bit
    always_comb begin
        rx_done = (rx_state == RX_STOP) && tick && (rx_s == SW'(SB_TICK - 1));
    end

    // Store only when there is room or a pop frees a slot in the same cycle
    assign rx_fifo_wr = rx_done & (~rx_fifo_full | rd_uart);

    uart_fifo #(.B(8), .W(FIFO_W)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd_uart),
        .wr     (rx_fifo_wr),
        .w_data (rx_b),
        .empty  (rx_empty),
        .full   (rx_fifo_full),
        .r_data (r_data)
    );

    uart_fifo #(.B(8), .W(FIFO_W)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (tx_pop),
        .wr     (wr_uart),
        .w_data (w_data),
        .empty  (tx_fifo_empty),
        .full   (tx_full),
        .r_data (tx_fifo_dout)
    );

    // Transmitter state, datapath and registered line output (idle high on reset)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_reg   <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_s     <= tx_s_n;
            tx_n     <= tx_n_n;
            tx_b     <= tx_b_n;
            tx_reg   <= tx_next;
        end
    end

    // Transmitter next state: start bit, DBIT data bits LSB first, stop bit, 16 ticks per bit
    always_comb begin
        tx_state_n = tx_state;
        tx_s_n     = tx_s;
        tx_n_n     = tx_n;
        tx_b_n     = tx_b;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_fifo_empty) begin
                    tx_state_n = TX_START;
                    tx_s_n     = '0;
                    tx_b_n     = tx_fifo_dout;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (tx_s == SW'(OS_LAST)) begin
                        tx_state_n = TX_DATA;
                        tx_s_n     = '0;
                        tx_n_n     = '0;
                    end else begin
                        tx_s_n = tx_s + 1'b1;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_s == SW'(OS_LAST)) begin
                        tx_s_n = '0;
                        tx_b_n = {1'b0, tx_b[7:1]};
                        if (tx_n == NW'(DBIT - 1)) tx_state_n = TX_STOP;
                        else tx_n_n = tx_n + 1'b1;
                    end else begin
                        tx_s_n = tx_s + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_s == SW'(SB_TICK - 1)) tx_state_n = TX_IDLE;
                    else tx_s_n = tx_s + 1'b1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // Transmitter outputs: line level per state and FIFO pop when a new frame is loaded
    always_comb begin
        tx_pop  = (tx_state == TX_IDLE) && !tx_fifo_empty;
        tx_next = 1'b1;
        case (tx_state)
            TX_START: tx_next = 1'b0;
            TX_DATA:  tx_next = tx_b[0];
            default:  tx_next = 1'b1;
        endcase
    end

    assign tx = tx_reg;

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: stimulus pushes expected bytes/frames, monitors decode and compare.
`timescale 1ns/1ps
module tb_uart;

    localparam int DVSR_TB = 5;
    localparam int BIT     = 16 * DVSR_TB;

    logic       clk;
    logic       reset;
    logic       rd_uart;
    logic       wr_uart;
    logic       rx_drv;
    logic       loop_en;
    logic [7:0] w_data;
    logic       tx_full;
    logic       rx_empty;
    logic       tx;
    logic [7:0] r_data;
    wire logic  rx;

    assign rx = loop_en ? tx : rx_drv;

    uart #(.DBIT(8), .SB_TICK(16), .DVSR(DVSR_TB), .FIFO_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_uart  (rd_uart),
        .wr_uart  (wr_uart),
        .rx       (rx),
        .w_data   (w_data),
        .tx_full  (tx_full),
        .rx_empty (rx_empty),
        .tx       (tx),
        .r_data   (r_data)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       auto_rd = 1'b0;
    logic [7:0] rx_q [$];
    logic [9:0] tx_q [$];
    logic [9:0] tx_frm;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // RX monitor: whenever a byte is presented and draining is enabled, compare and pop it
    initial begin
        rd_uart = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_rd && !rx_empty) begin
                if (rx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got %0h, expected no byte", r_data);
                end else begin
                    chk("rx_byte", {24'b0, r_data}, {24'b0, rx_q.pop_front()});
                end
                rd_uart = 1'b1;
            end else begin
                rd_uart = 1'b0;
            end
        end
    end

    // TX monitor: on a start edge, sample ten bits at mid-bit and compare the whole frame
    initial begin
        forever begin
            @(negedge tx);
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                tx_frm[i] = tx;
                if (i < 9) repeat (BIT) @(negedge clk);
            end
            if (tx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_unexpected: got frame %0h, expected none", tx_frm);
            end else begin
                chk("tx_frame", {22'b0, tx_frm}, {22'b0, tx_q.pop_front()});
            end
        end
    end

    // Drive one serial frame on rx: start, 8 data bits LSB first, stop level for stop_len clocks
    task automatic send_frame(input logic [7:0] data, input logic stop_lvl, input int stop_len);
        rx_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = data[i];
            repeat (BIT) @(negedge clk);
        end
        rx_drv = stop_lvl;
        repeat (stop_len) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * BIT) @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        w_data  = b;
        wr_uart = 1'b1;
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    logic [7:0] burst [5];
    logic [7:0] lb    [3];

    initial begin
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        lb    = '{8'h00, 8'hFF, 8'h55};
        reset   = 1'b1;
        wr_uart = 1'b0;
        w_data  = 8'h00;
        rx_drv  = 1'b1;
        loop_en = 1'b0;
        #1 reset = 1'b0;

        // Reset state, while held and after release
        repeat (20) @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_rx_empty", {31'b0, rx_empty}, 32'd1);
        chk("rst_tx_full", {31'b0, tx_full}, 32'd0);
        chk("rst_r_data", {24'b0, r_data}, 32'h00);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_tx", {31'b0, tx}, 32'd1);
        chk("idle_rx_empty", {31'b0, rx_empty}, 32'd1);

        // RX: bits 1,1,1,0,0,1,1,1 -> 0xE7, held in FIFO without reading
        send_frame(8'hE7, 1'b1, BIT);
        chk("rx1_empty", {31'b0, rx_empty}, 32'd0);
        chk("rx1_data", {24'b0, r_data}, 32'hE7);

        // RX: bits 0,0,0,1,1,0,0,0 with a low stop bit -> 0x18 still stored
        send_frame(8'h18, 1'b0, (3 * BIT) / 4);
        chk("rx2_head", {24'b0, r_data}, 32'hE7);
        rx_q.push_back(8'hE7);
        rx_q.push_back(8'h18);
        auto_rd = 1'b1;
        repeat (10) @(negedge clk);
        chk("rx_drained_empty", {31'b0, rx_empty}, 32'd1);

        // One-tick low glitch on idle rx is rejected
        rx_drv = 1'b0;
        repeat (DVSR_TB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        chk("glitch_rx_empty", {31'b0, rx_empty}, 32'd1);

        // TX: 0xA5 waveform 0,1,0,1,0,0,1,0,1,1 then a 5-byte burst while it is sending
        tx_q.push_back(10'b11_0100_1010);
        push_byte(8'hA5);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            w_data  = burst[i];
            wr_uart = 1'b1;
            if (i < 4) tx_q.push_back({1'b1, burst[i], 1'b0});
            @(negedge clk);
            chk($sformatf("tx_full_%0d", i), {31'b0, tx_full}, (i >= 3) ? 32'd1 : 32'd0);
        end
        wr_uart = 1'b0;
        repeat (60 * BIT) @(negedge clk);
        chk("tx_burst_full_clear", {31'b0, tx_full}, 32'd0);
        chk("tx_idle_high", {31'b0, tx}, 32'd1);

        // Loopback tx -> rx
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back({1'b1, lb[i], 1'b0});
            rx_q.push_back(lb[i]);
        end
        for (int i = 0; i < 3; i++) begin
            w_data  = lb[i];
            wr_uart = 1'b1;
            @(negedge clk);
        end
        wr_uart = 1'b0;
        repeat (40 * BIT) @(negedge clk);

        chk("rx_queue_left", rx_q.size(), 32'd0);
        chk("tx_queue_left", tx_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
